// File: rtl/sdram_ref_if.sv
// Refresh scheduler <-> arbiter signal bundle. The scheduler side is the master:
// it raises requests and drives the command bus, and the arbiter side answers with grants.
interface sdram_ref_if #(
   parameter int BA_W   = 2,
   parameter int ADDR_W = 13,
   parameter int DEBT_W = 4
);
   logic              init_end;
   logic              ref_en;
   logic              ref_req;
   logic              ref_urgent;
   logic [3:0]        ref_cmd;
   logic [BA_W-1:0]   ref_ba;
   logic [ADDR_W-1:0] ref_addr;
   logic              ref_end;
   logic [DEBT_W-1:0] ref_debt;
   logic              ref_overflow;

   modport master (
      input  init_end, ref_en,
      output ref_req, ref_urgent, ref_cmd, ref_ba, ref_addr, ref_end, ref_debt, ref_overflow
   );

   modport slave (
      output init_end, ref_en,
      input  ref_req, ref_urgent, ref_cmd, ref_ba, ref_addr, ref_end, ref_debt, ref_overflow
   );
endinterface

// File: rtl/sdram_ref_sched.sv
// Auto-refresh scheduler: accrues refresh debt on every tREFI tick and, once the arbiter
// grants it, drains up to MAX_BURST refreshes as PRECHARGE-all followed by AUTO_REFRESH bursts.
module sdram_ref_sched #(
   parameter int T_REFI_CLK = 781,
   parameter int T_RP_CLK   = 2,
   parameter int T_RFC_CLK  = 7,
   parameter int MAX_DEBT   = 8,
   parameter int URGENT_LVL = 6,
   parameter int MAX_BURST  = 2,
   parameter int BA_W       = 2,
   parameter int ADDR_W     = 13,
   parameter int DEBT_W     = 4
) (
   input logic         sys_clk,
   input logic         sys_rst,
   sdram_ref_if.master bus
);
   localparam int CNT_W    = $clog2(T_REFI_CLK);
   localparam int WAIT_MAX = (T_RP_CLK > T_RFC_CLK) ? T_RP_CLK : T_RFC_CLK;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int BURST_W  = $clog2(MAX_BURST + 1);

   localparam logic [CNT_W-1:0]  REFI_LAST = CNT_W'(T_REFI_CLK - 1);
   localparam logic [WAIT_W-1:0] RP_LAST   = WAIT_W'(T_RP_CLK - 1);
   localparam logic [WAIT_W-1:0] RFC_LAST  = WAIT_W'(T_RFC_CLK - 1);
   localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_DEBT);
   localparam logic [DEBT_W-1:0] DEBT_URG  = DEBT_W'(URGENT_LVL);
   localparam logic [DEBT_W-1:0] BURST_CAP = DEBT_W'(MAX_BURST);
   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_TRP, S_AR, S_TRFC, S_END} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DEBT_W-1:0]   debt_q, debt_d;
   logic                ovf_q, ovf_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [BURST_W-1:0]  n_q, n_d;
   logic [BURST_W-1:0]  done_q, done_d;
   logic [3:0]          cmd_q, cmd_d;
   logic                end_q, end_d;
   logic                tick;
   logic                ar_issue;
   logic                req;

   assign tick     = bus.init_end && (cnt_q == REFI_LAST);
   assign ar_issue = (state_q == S_AR);
   assign req      = (state_q == S_IDLE) && (debt_q != '0) && bus.init_end;

   always_comb begin
      cnt_d  = '0;
      debt_d = debt_q;
      ovf_d  = ovf_q | (tick && (debt_q == DEBT_MAX));
      if (bus.init_end && !tick) cnt_d = cnt_q + 1'b1;
      if (tick && !ar_issue && (debt_q != DEBT_MAX)) debt_d = debt_q + 1'b1;
      else if (ar_issue && !tick)                    debt_d = debt_q - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      n_d     = n_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE: if (req && bus.ref_en) begin
            state_d = S_PRE;
            n_d     = (debt_q > BURST_CAP) ? BURST_W'(MAX_BURST) : BURST_W'(debt_q);
            done_d  = '0;
         end
         S_PRE: begin
            state_d = S_TRP;
            wait_d  = '0;
         end
         S_TRP: begin
            if (wait_q == RP_LAST) state_d = S_AR;
            else                   wait_d  = wait_q + 1'b1;
         end
         S_AR: begin
            state_d = S_TRFC;
            wait_d  = '0;
            done_d  = done_q + 1'b1;
         end
         S_TRFC: begin
            if (wait_q == RFC_LAST) state_d = (done_q < n_q) ? S_AR : S_END;
            else                    wait_d  = wait_q + 1'b1;
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Command/end registers load from the next state so PRECHARGE appears the cycle after the grant.
      cmd_d = CMD_NOP;
      if (state_d == S_PRE) cmd_d = CMD_PRE;
      if (state_d == S_AR)  cmd_d = CMD_AR;
      end_d = (state_d == S_END);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         debt_q  <= '0;
         ovf_q   <= 1'b0;
         wait_q  <= '0;
         n_q     <= '0;
         done_q  <= '0;
         cmd_q   <= CMD_NOP;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         debt_q  <= debt_d;
         ovf_q   <= ovf_d;
         wait_q  <= wait_d;
         n_q     <= n_d;
         done_q  <= done_d;
         cmd_q   <= cmd_d;
         end_q   <= end_d;
      end
   end

   assign bus.ref_req      = req;
   assign bus.ref_urgent   = (debt_q >= DEBT_URG);
   assign bus.ref_cmd      = cmd_q;
   assign bus.ref_ba       = {BA_W{1'b1}};
   assign bus.ref_addr     = {ADDR_W{1'b1}};
   assign bus.ref_end      = end_q;
   assign bus.ref_debt     = debt_q;
   assign bus.ref_overflow = ovf_q;
endmodule

// File: tb/tb_sdram_ref_sched.sv
// Bench for sdram_ref_sched: an event-list reference model predicts burst command timing and debt,
// and a negedge monitor pops expected events whenever the DUT shows a command or ref_end.
module tb_sdram_ref_sched;
   localparam int T_REFI = 781;
   localparam int T_RP   = 2;
   localparam int T_RFC  = 7;
   localparam int MAXD   = 8;
   localparam int URG    = 6;
   localparam int MAXB   = 2;
   localparam int BA_W   = 2;
   localparam int ADDR_W = 13;
   localparam int DEBT_W = 4;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] AR  = 4'b0001;
   localparam int K_PRE = 1, K_AR = 3, K_END = 4, K_BAD = 9;

   typedef struct {int kind; longint cyc;} ev_t;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;

   sdram_ref_if #(.BA_W(BA_W), .ADDR_W(ADDR_W), .DEBT_W(DEBT_W)) bus ();

   sdram_ref_sched #(
      .T_REFI_CLK(T_REFI), .T_RP_CLK(T_RP), .T_RFC_CLK(T_RFC), .MAX_DEBT(MAXD),
      .URGENT_LVL(URG), .MAX_BURST(MAXB), .BA_W(BA_W), .ADDR_W(ADDR_W), .DEBT_W(DEBT_W)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus    (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;

   // Reference model state
   int     m_cnt = 0, m_debt = 0, m_ticks = 0;
   bit     m_ovf = 1'b0;
   longint m_end_cyc = -1;
   ev_t    exp_q[$];
   longint ar_q[$];
   bit     mt_tick, mt_ar, mt_grant;
   int     mt_n;
   longint mt_base;
   ev_t    mt_ev;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: debt and burst timing derived from cycle arithmetic on grant/tick events.
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         m_cnt = 0; m_debt = 0; m_ovf = 1'b0; m_end_cyc = -1;
         exp_q.delete(); ar_q.delete();
      end else begin
         mt_tick = bus.init_end && (m_cnt == T_REFI - 1);
         mt_ar = 1'b0;
         if (ar_q.size() > 0) begin
            if (ar_q[0] == cyc) begin
               mt_ar = 1'b1;
               void'(ar_q.pop_front());
            end
         end
         mt_grant = (cyc > m_end_cyc) && (m_debt != 0) && bus.init_end && bus.ref_en;
         if (mt_grant) begin
            mt_n = (m_debt < MAXB) ? m_debt : MAXB;
            mt_base = cyc + 2 + T_RP;
            mt_ev.kind = K_PRE; mt_ev.cyc = cyc + 1; exp_q.push_back(mt_ev);
            for (int i = 0; i < mt_n; i++) begin
               mt_ev.kind = K_AR; mt_ev.cyc = mt_base + i * (1 + T_RFC);
               exp_q.push_back(mt_ev);
               ar_q.push_back(mt_ev.cyc);
            end
            m_end_cyc = mt_base + mt_n * (1 + T_RFC);
            mt_ev.kind = K_END; mt_ev.cyc = m_end_cyc; exp_q.push_back(mt_ev);
         end
         if (mt_tick) begin
            m_ticks++;
            if (m_debt == MAXD) m_ovf = 1'b1;
         end
         if (mt_tick && !mt_ar)      m_debt = (m_debt < MAXD) ? m_debt + 1 : MAXD;
         else if (mt_ar && !mt_tick) m_debt = m_debt - 1;
         m_cnt = (!bus.init_end || mt_tick) ? 0 : m_cnt + 1;
         cyc++;
      end
   end

   // Monitor
   int  mon_kind;
   ev_t mon_ev;
   always @(negedge sys_clk) begin
      mon_kind = 0;
      if (bus.ref_end)             mon_kind = K_END;
      else if (bus.ref_cmd == PRE) mon_kind = K_PRE;
      else if (bus.ref_cmd == AR)  mon_kind = K_AR;
      else if (bus.ref_cmd != NOP) mon_kind = K_BAD;
      if (bus.ref_end && bus.ref_cmd != NOP) mon_kind = K_BAD;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         mon_ev = exp_q.pop_front();
         total++; bad++;
         $display("FAIL evt_missed: kind %0d due at cycle %0d not seen (now %0d)", mon_ev.kind, mon_ev.cyc, cyc);
      end
      if (mon_kind != 0) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL evt_unexpected: kind %0d cmd %b at cycle %0d, none expected", mon_kind, bus.ref_cmd, cyc);
         end else begin
            mon_ev = exp_q.pop_front();
            chk("evt_kind", mon_kind, mon_ev.kind);
            chk("evt_cycle", cyc, mon_ev.cyc);
         end
      end
      chk("debt", bus.ref_debt, m_debt);
      chk("req", bus.ref_req, (cyc > m_end_cyc) && (m_debt != 0) && bus.init_end);
      chk("urgent", bus.ref_urgent, m_debt >= URG);
      chk("overflow", bus.ref_overflow, m_ovf);
      chk("ba", bus.ref_ba, (1 << BA_W) - 1);
      chk("addr", bus.ref_addr, (1 << ADDR_W) - 1);
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic start_phase();
      step();
      sys_rst = 1'b1; bus.init_end = 1'b0; bus.ref_en = 1'b0;
      repeat (2) step();
      sys_rst = 1'b0; bus.init_end = 1'b1;
   endtask

   task automatic wait_ticks(input int n);
      int target = m_ticks + n;
      int guard = 0;
      while (m_ticks < target && guard < n * T_REFI + 20) begin
         step();
         guard++;
      end
      if (m_ticks < target) chk("tick_timeout", m_ticks, target);
   endtask

   task automatic wait_cmd(input logic [3:0] c, input string name);
      int guard = 0;
      while (bus.ref_cmd != c && guard < 200) begin
         step();
         guard++;
      end
      chk(name, bus.ref_cmd, c);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      longint c0;
      int guard;
      int drop;
      int pct;
      bus.init_end = 1'b0;
      bus.ref_en   = 1'b0;
      sys_rst      = 1'b1;
      repeat (3) step();
      chk("rst_cmd", bus.ref_cmd, NOP);
      chk("rst_ba", bus.ref_ba, (1 << BA_W) - 1);
      chk("rst_addr", bus.ref_addr, (1 << ADDR_W) - 1);
      chk("rst_req", bus.ref_req, 0);
      chk("rst_end", bus.ref_end, 0);
      chk("rst_debt", bus.ref_debt, 0);
      chk("rst_ovf", bus.ref_overflow, 0);
      chk("rst_urgent", bus.ref_urgent, 0);
      sys_rst = 1'b0;

      // init_end low: no debt, no request; first request 781 cycles after it rises
      for (int i = 0; i < 2000; i++) begin
         bus.ref_en = 1'($urandom_range(0, 1));
         step();
      end
      chk("init_low_debt", bus.ref_debt, 0);
      bus.ref_en = 1'b1; bus.init_end = 1'b1;
      c0 = cyc; guard = 0;
      while (bus.ref_req !== 1'b1 && guard < T_REFI + 20) begin
         step();
         guard++;
      end
      chk("first_req_lat", cyc - c0, T_REFI);
      wait_ticks(2);
      repeat (30) step();
      chk("steady_debt", bus.ref_debt, 0);

      // three postponed refreshes, then bursts of 2 and 1
      start_phase();
      wait_ticks(3);
      chk("debt3", bus.ref_debt, 3);
      chk("req3", bus.ref_req, 1);
      bus.ref_en = 1'b1;
      wait_cmd(AR, "burst2_ar");
      repeat (60) step();
      chk("debt3_drained", bus.ref_debt, 0);

      // urgent threshold
      start_phase();
      wait_ticks(5);
      chk("urgent5", bus.ref_urgent, 0);
      wait_ticks(1);
      chk("urgent6", bus.ref_urgent, 1);
      chk("debt6", bus.ref_debt, 6);
      bus.ref_en = 1'b1;
      wait_cmd(AR, "urgent_ar");
      step();
      chk("debt_after_ar", bus.ref_debt, 5);
      chk("urgent_after_ar", bus.ref_urgent, 0);
      repeat (100) step();

      // saturation and sticky overflow
      start_phase();
      wait_ticks(8);
      chk("debt8", bus.ref_debt, 8);
      chk("ovf_before", bus.ref_overflow, 0);
      wait_ticks(1);
      chk("debt_sat", bus.ref_debt, 8);
      chk("ovf_set", bus.ref_overflow, 1);
      bus.ref_en = 1'b1;
      repeat (120) step();
      chk("ovf_drained_debt", bus.ref_debt, 0);
      chk("ovf_sticky", bus.ref_overflow, 1);
      sys_rst = 1'b1;
      #1;
      chk("ovf_cleared", bus.ref_overflow, 0);

      // tick coincident with AUTO_REFRESH, then reset during tRFC
      start_phase();
      wait_ticks(1);
      guard = 0;
      while (m_cnt != T_REFI - 3 - T_RP && guard < T_REFI + 10) begin
         step();
         guard++;
      end
      bus.ref_en = 1'b1;
      step();
      bus.ref_en = 1'b0;
      wait_cmd(AR, "coinc_ar");
      chk("coinc_debt_before", bus.ref_debt, 1);
      step();
      chk("coinc_debt_after", bus.ref_debt, 1);
      repeat (20) step();
      wait_ticks(1);
      chk("debt_before_rst", bus.ref_debt, 2);
      bus.ref_en = 1'b1;
      wait_cmd(AR, "rst_burst_ar");
      bus.ref_en = 1'b0;
      repeat (3) step();
      #3;
      sys_rst = 1'b1;
      #1;
      chk("midrst_cmd", bus.ref_cmd, NOP);
      chk("midrst_req", bus.ref_req, 0);
      chk("midrst_debt", bus.ref_debt, 0);
      chk("midrst_end", bus.ref_end, 0);
      repeat (2) step();
      sys_rst = 1'b0;
      bus.ref_en = 1'b1;
      repeat (20) step();
      chk("no_resume_cmd", bus.ref_cmd, NOP);

      // randomized traffic against the model
      start_phase();
      drop = 0;
      pct = 50;
      for (int i = 0; i < 16000; i++) begin
         if (i % 2000 == 0) pct = $urandom_range(0, 100);
         bus.ref_en = ($urandom_range(0, 99) < pct);
         if (drop > 0) begin
            bus.init_end = 1'b0;
            drop--;
         end else begin
            bus.init_end = 1'b1;
            if ($urandom_range(0, 2999) == 0) drop = $urandom_range(1, 50);
         end
         step();
      end
      bus.init_end = 1'b1;
      bus.ref_en = 1'b0;
      repeat (40) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
